ahb_imem_responder: RTL and testbench

AHB_IMEM_RESPONDER -- requirements
Module: ahb_imem_responder

---
 rtl/ahb_imem_pkg.sv | 29 ++
 rtl/fetch_log_fifo.sv | 64 ++++++
 rtl/ahb_imem_responder.sv | 101 ++++++++++
 tb/tb_ahb_imem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_imem_pkg.sv
// Shared types and constants for the AHB instruction-memory responder.
// FSM state encoding, AHB transfer/size codes and the NOP filler word.
package ahb_imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0]  HSIZE_WORD = 3'b010;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  function automatic logic fetch_err(
    input logic       err,
    input logic       write,
    input logic [2:0] size,
    input logic [1:0] lsb
  );
    return err | write | (size != HSIZE_WORD) | (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_log_fifo.sv
// Synchronous FIFO of issued {pc, insn} fetch records.
// Drops pushes when full (unless popping) and flags it stickily.
module fetch_log_fifo #(
  parameter int          LOG_DEPTH = 8,
  parameter logic [31:0] PC_INIT   = 32'h200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_insn,
  input  logic        pop,
  output logic        valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_insn,
  output logic        full,
  output logic        overflow
);
  import ahb_imem_pkg::*;

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LOG_DEPTH);

  logic [63:0]   mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic          do_push;
  logic          do_pop;

  assign valid    = (count != '0);
  assign full     = (count == FULL_CNT);
  assign overflow = ovf_q;
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);

  assign {head_pc, head_insn} = valid ? mem[rd_ptr]
                                      : {PC_INIT, NOP_INSN};

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_pc, push_insn};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !do_pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ahb_imem_responder.sv
// AHB3-Lite instruction-fetch responder with wait/error injection
// and a log of every successfully completed fetch.
module ahb_imem_responder #(
  parameter int          LOG_DEPTH = 8,
  parameter logic [31:0] PC_INIT   = 32'h200
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] insn_i,
  input  logic [1:0]  wait_i,
  input  logic        err_i,
  output logic        log_valid_o,
  input  logic        log_ready_i,
  output logic [31:0] log_pc_o,
  output logic [31:0] log_insn_o,
  output logic        log_full_o,
  output logic        log_overflow_o
);
  import ahb_imem_pkg::*;

  state_e      state;
  logic        pend;
  logic [1:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] insn_q;
  logic        active;
  logic        accept;
  logic        cause;
  logic        done;

  assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign accept = HSEL && active && HREADY;
  assign cause  = fetch_err(err_i, HWRITE, HSIZE, HADDR[1:0]);

  // pend marks an OKAY data phase completing in the current IDLE cycle
  assign done      = (state == ST_IDLE) && pend;
  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign HRDATA    = done ? insn_q : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      pend   <= 1'b0;
      cnt    <= 2'd0;
      addr_q <= 32'h0;
      insn_q <= 32'h0;
    end else begin
      pend <= 1'b0;
      unique case (state)
        ST_IDLE, ST_ERR2: begin
          state <= ST_IDLE;
          if (accept) begin
            addr_q <= HADDR;
            insn_q <= insn_i;
            cnt    <= wait_i;
            if (cause)              state <= ST_ERR1;
            else if (wait_i != 2'd0) state <= ST_WAIT;
            else                    pend  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt <= 2'd1) begin
            state <= ST_IDLE;
            pend  <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
      endcase
    end
  end

  fetch_log_fifo #(
    .LOG_DEPTH (LOG_DEPTH),
    .PC_INIT   (PC_INIT)
  ) u_log (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (done),
    .push_pc   (addr_q),
    .push_insn (insn_q),
    .pop       (log_ready_i),
    .valid     (log_valid_o),
    .head_pc   (log_pc_o),
    .head_insn (log_insn_o),
    .full      (log_full_o),
    .overflow  (log_overflow_o)
  );

endmodule

// File: tb/tb_ahb_imem_responder.sv
// Directed self-checking bench for ahb_imem_responder.
// Table of single fetches plus hand sequences for FIFO and reset cases.
module tb_ahb_imem_responder;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] insn_i;
  logic [1:0]  wait_i;
  logic        err_i;
  logic        log_valid_o;
  logic        log_ready_i;
  logic [31:0] log_pc_o;
  logic [31:0] log_insn_o;
  logic        log_full_o;
  logic        log_overflow_o;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_imem_responder #(.LOG_DEPTH(8), .PC_INIT(32'h200)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HSEL           (HSEL),
    .HADDR          (HADDR),
    .HWRITE         (HWRITE),
    .HSIZE          (HSIZE),
    .HTRANS         (HTRANS),
    .HREADY         (HREADY),
    .HRDATA         (HRDATA),
    .HREADYOUT      (HREADYOUT),
    .HRESP          (HRESP),
    .insn_i         (insn_i),
    .wait_i         (wait_i),
    .err_i          (err_i),
    .log_valid_o    (log_valid_o),
    .log_ready_i    (log_ready_i),
    .log_pc_o       (log_pc_o),
    .log_insn_o     (log_insn_o),
    .log_full_o     (log_full_o),
    .log_overflow_o (log_overflow_o)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [1:0]  wt;
    logic        err;
    logic [31:0] insn;
    int          e_wait;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_push;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HADDR  = 32'h0;
    wait_i = 2'd0;
    err_i  = 1'b0;
    insn_i = 32'hffff_ffff;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] ins);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HADDR  = a;
    wait_i = w;
    err_i  = 1'b0;
    insn_i = ins;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int   n;
    logic rlow;
    HSEL   = v.sel;
    HTRANS = v.trans;
    HWRITE = v.write;
    HSIZE  = v.size;
    HADDR  = v.addr;
    wait_i = v.wt;
    err_i  = v.err;
    insn_i = v.insn;
    tick();
    idle_bus();
    n    = 0;
    rlow = 1'b0;
    @(negedge HCLK);
    while (!HREADYOUT && n < 8) begin
      n++;
      rlow |= HRESP;
      @(negedge HCLK);
    end
    chk($sformatf("v%0d waits", i), 64'(n), 64'(v.e_wait));
    chk($sformatf("v%0d resp", i), {62'd0, rlow, HRESP},
        {62'd0, v.e_resp, v.e_resp});
    chk($sformatf("v%0d rdata", i), 64'(HRDATA), 64'(v.e_rdata));
    @(posedge HCLK);
    @(negedge HCLK);
    chk($sformatf("v%0d logv", i), 64'(log_valid_o), 64'(v.e_push));
    if (v.e_push) begin
      chk($sformatf("v%0d logpc", i), 64'(log_pc_o), 64'(v.addr));
      chk($sformatf("v%0d logins", i), 64'(log_insn_o), 64'(v.insn));
    end
    tick();
  endtask

  task automatic quick_fetch(input logic [31:0] a, input logic [31:0] ins);
    drive(a, 2'd0, ins);
    tick();
    idle_bus();
    tick();
  endtask

  task automatic pop_check(input string nm, input logic [31:0] pc,
                           input logic [31:0] ins);
    @(negedge HCLK);
    chk({nm, " v"}, 64'(log_valid_o), 64'd1);
    chk({nm, " pc"}, 64'(log_pc_o), 64'(pc));
    chk({nm, " ins"}, 64'(log_insn_o), 64'(ins));
    log_ready_i = 1'b1;
    tick();
    log_ready_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " rdy"}, 64'(HREADYOUT), 64'd1);
    chk({nm, " resp"}, 64'(HRESP), 64'd0);
    chk({nm, " rdata"}, 64'(HRDATA), 64'd0);
    chk({nm, " logv"}, 64'(log_valid_o), 64'd0);
    chk({nm, " full"}, 64'(log_full_o), 64'd0);
    chk({nm, " ovf"}, 64'(log_overflow_o), 64'd0);
    chk({nm, " pc"}, 64'(log_pc_o), 64'h200);
    chk({nm, " ins"}, 64'(log_insn_o), 64'h13);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    //          sel   trans  wr    size    addr         wt    err   insn          w  rsp   rdata         push
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h200, 2'd0, 1'b0, 32'h00100093, 0, 1'b0, 32'h00100093, 1'b1};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h204, 2'd3, 1'b0, 32'h00200113, 3, 1'b0, 32'h00200113, 1'b1};
    vecs[2]  = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h208, 2'd0, 1'b0, 32'h11111111, 1, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h20A, 2'd2, 1'b0, 32'h22222222, 1, 1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 3'b010, 32'h20C, 2'd1, 1'b0, 32'h00308193, 1, 1'b0, 32'h00308193, 1'b1};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 3'b001, 32'h210, 2'd0, 1'b0, 32'h33333333, 1, 1'b1, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h214, 2'd1, 1'b1, 32'h44444444, 1, 1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 3'b010, 32'h218, 2'd2, 1'b0, 32'h55555555, 0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 3'b010, 32'h218, 2'd2, 1'b0, 32'h66666666, 0, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 3'b010, 32'h218, 2'd2, 1'b0, 32'h77777777, 0, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h21C, 2'd2, 1'b0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 1'b1};

    HRESETn     = 1'b0;
    log_ready_i = 1'b1;
    idle_bus();
    repeat (2) @(negedge HCLK);
    chk_reset_vals("rst");
    tick();
    HRESETn = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // back-to-back fetches with no idle cycle
    log_ready_i = 1'b0;
    drive(32'h300, 2'd0, 32'hA0A0A0A0);
    tick();
    drive(32'h304, 2'd0, 32'hB0B0B0B0);
    @(negedge HCLK);
    chk("b2b1 rdy", 64'(HREADYOUT), 64'd1);
    chk("b2b1 rdata", 64'(HRDATA), 64'hA0A0A0A0);
    tick();
    idle_bus();
    @(negedge HCLK);
    chk("b2b2 rdy", 64'(HREADYOUT), 64'd1);
    chk("b2b2 rdata", 64'(HRDATA), 64'hB0B0B0B0);
    tick();
    pop_check("b2b pop0", 32'h300, 32'hA0A0A0A0);
    pop_check("b2b pop1", 32'h304, 32'hB0B0B0B0);

    // fill to full, then overflow with a ninth fetch
    for (int i = 0; i < 8; i++) quick_fetch(32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
    @(negedge HCLK);
    chk("fill full", 64'(log_full_o), 64'd1);
    chk("fill ovf", 64'(log_overflow_o), 64'd0);
    tick();
    quick_fetch(32'h420, 32'h0BAD0BAD);
    @(negedge HCLK);
    chk("ovf full", 64'(log_full_o), 64'd1);
    chk("ovf flag", 64'(log_overflow_o), 64'd1);
    tick();
    for (int i = 0; i < 8; i++)
      pop_check($sformatf("drain%0d", i), 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
    @(negedge HCLK);
    chk("drain logv", 64'(log_valid_o), 64'd0);
    chk("drain full", 64'(log_full_o), 64'd0);
    chk("drain ovf", 64'(log_overflow_o), 64'd1);
    tick();

    // push and pop together while full
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) quick_fetch(32'h500 + 32'(4 * i), 32'h2000 + 32'(i));
    drive(32'h520, 2'd0, 32'h00002008);
    tick();
    idle_bus();
    log_ready_i = 1'b1;
    tick();
    log_ready_i = 1'b0;
    @(negedge HCLK);
    chk("pp full", 64'(log_full_o), 64'd1);
    chk("pp ovf", 64'(log_overflow_o), 64'd0);
    chk("pp head", 64'(log_pc_o), 64'h504);
    tick();

    // reset in the middle of a wait-state fetch
    drive(32'h604, 2'd3, 32'h00400213);
    tick();
    idle_bus();
    @(negedge HCLK);
    chk("mid rdy", 64'(HREADYOUT), 64'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    HRESETn     = 1'b1;
    log_ready_i = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("midrst nopush", 64'(log_valid_o), 64'd0);
    tick();
    run_vec(1, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
